// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one start/done multiplier among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 128,
  localparam int IDW = $clog2(NUM_REQ) + 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [IDW-1:0]           resp_id,
  output logic [2*WIDTH-1:0]       resp_prod,
  output logic                     resp_err,
  output logic                     mult_start,
  output logic [WIDTH-1:0]         mult_a,
  output logic [WIDTH-1:0]         mult_b,
  input  logic                     mult_done,
  input  logic [2*WIDTH-1:0]       mult_product
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3;
  logic [1:0] state;
  logic [IDW-1:0] rr_ptr, grant;
  int idx;
  if (NUM_REQ < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mult_arbiter: NUM_REQ and TIMEOUT_CYCLES must be at least 1");
  end
`ifdef MULT_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] timer;
`else
  assign resp_err = 1'b0;
`endif
  // lowest rotation offset from rr_ptr wins, so scan offsets from the far end down
  always_comb begin
    grant = '0;
    idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req_valid[idx]) grant = IDW'(idx);
    end
  end
  assign req_ready  = (state == IDLE && |req_valid && !Reset) ? NUM_REQ'(1) << grant : '0;
  assign resp_valid = state == RESP;
  assign mult_start = state == ISSUE;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      mult_a    <= '0;
      mult_b    <= '0;
      resp_id   <= '0;
      resp_prod <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
      timer     <= '0;
      resp_err  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          mult_a  <= req_a[int'(grant)*WIDTH +: WIDTH];
          mult_b  <= req_b[int'(grant)*WIDTH +: WIDTH];
          resp_id <= grant;
`ifdef MULT_ARB_TIMEOUT_EN
          resp_err <= 1'b0;
`endif
          state   <= ISSUE;
        end
        ISSUE: begin
`ifdef MULT_ARB_TIMEOUT_EN
          timer <= '0;
`endif
          state <= WAIT;
        end
        WAIT: if (mult_done) begin
          resp_prod <= mult_product;
          state     <= RESP;
        end
`ifdef MULT_ARB_TIMEOUT_EN
        else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          resp_prod <= '0;
          resp_err  <= 1'b1;
          state     <= RESP;
        end else timer <= timer + 1'b1;
`endif
        default: if (resp_ready) begin
          rr_ptr <= (resp_id == IDW'(NUM_REQ - 1)) ? '0 : resp_id + 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule
